// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the memory-mapped UART transmitter.
//   uart_state_e - transmitter FSM state encoding
//   TXDATA_OFF   - addr_i[2] value selecting the TXDATA register
//   STATUS_OFF   - addr_i[2] value selecting the STATUS register
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic TXDATA_OFF = 1'b0;
  localparam logic STATUS_OFF = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB read/write pointers.
//   clk, rst_n - clock, asynchronous active-low reset (discards contents)
//   push_i     - write wdata_i; ignored when full unless pop_i is also accepted
//   pop_i      - drop the head entry; ignored when empty
//   wdata_i    - data to push
//   rdata_o    - head entry, read combinationally
//   full_o     - DEPTH entries held
//   empty_o    - no entries held
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop_ok  = pop_i && !empty_o;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = push_i && (!full_o || w_pop_ok);

  assign rdata_o = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
//   clk, rst_n - clock, asynchronous active-low reset
//   addr_i     - CPU data address; window is BASE_ADDR[31:3], register on addr_i[2]
//   wdata_i    - CPU write data
//   wr_i       - CPU write strobe
//   sel_o      - combinational window hit
//   rdata_o    - registered read data (one cycle after addr_i)
//   tx_o       - serial line, idles high, driven from a flop
//   busy_o     - FIFO non-empty or a frame in progress
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_F000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        wr_i,
  output logic        sel_o,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int unsigned       BaudW   = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0]  BaudMax = BaudW'(CLKS_PER_BIT - 1);

  uart_state_e      r_state;
  logic [BaudW-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_ovf;
  logic [31:0]      r_rdata;

  logic       w_wr_en;
  logic       w_push;
  logic       w_pop;
  logic       w_clr_ovf;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_fifo_rdata;
  logic       w_unused;

  assign sel_o     = (addr_i[31:3] == BASE_ADDR[31:3]);
  assign w_wr_en   = wr_i && sel_o;
  assign w_push    = w_wr_en && (addr_i[2] == TXDATA_OFF);
  assign w_clr_ovf = w_wr_en && (addr_i[2] == STATUS_OFF) && wdata_i[3];
  assign w_unused  = ^{addr_i[1:0], wdata_i[31:8]};

  // The FSM pops when it starts a frame: from IDLE, or straight out of the
  // last STOP cycle so back-to-back frames have no gap.
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && (r_baud == '0)));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (wdata_i[7:0]),
    .rdata_o (w_fifo_rdata),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (w_clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (sel_o && (addr_i[2] == STATUS_OFF)) begin
      r_rdata <= {28'd0, r_ovf, (r_state != IDLE), w_empty, w_full};
    end else begin
      r_rdata <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= START;
            r_baud  <= BaudMax;
            r_shift <= w_fifo_rdata;
            r_tx    <= 1'b0;
          end
        end
        START: begin
          if (r_baud == '0) begin
            r_state   <= DATA;
            r_baud    <= BaudMax;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
          end else begin
            r_baud <= r_baud - BaudW'(1);
          end
        end
        DATA: begin
          if (r_baud == '0) begin
            r_baud <= BaudMax;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud - BaudW'(1);
          end
        end
        STOP: begin
          if (r_baud == '0) begin
            if (w_pop) begin
              r_state <= START;
              r_baud  <= BaudMax;
              r_shift <= w_fifo_rdata;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud - BaudW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_o    = r_tx;
  assign rdata_o = r_rdata;
  assign busy_o  = !w_empty || (r_state != IDLE);

endmodule
